shared_counter_pool: RTL and testbench
======================================

# shared_counter_pool

Parametrised successor to the shared-counter block. A pool of N slices of G bits each is carved at run time into variable-length counters. Each counter is one contiguous run of slices, identified by its base slice index. Adds several features: decrement, per-counter wrap/saturate mode, sticky overflow flags, first-fit allocation with explicit failure, a command-ready handshake, and illegal-command reporting. Sits between the command front-end and the statistics readout path.

## Interface
Parameters:
- N, 10, number of slices in the pool
- G, 4, bits per slice
- LW, 64, load data width; must satisfy LW >= N*G
- IW, $clog2(N), id/slice index width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- command_in  in  3  command code: 000 idle, 001 inc, 010 alloc, 011 dealloc, 100 load, 101 read, 110 dec, 111 clear
- id  in  IW  target counter (base slice index) for inc/dec/dealloc/load/read/clear
- new_counter_size  in  IW+1  slices requested by alloc, valid range 1..N
- new_counter_sat  in  1  alloc mode: 1 saturate, 0 wrap
- load_data_in  in  LW  load value; low size*G bits used
- valid_load_data  in  1  qualifies load; a load with this low is illegal
- ready  out  1  command accepted this cycle when high
- data_out  out  N*G  live slice contents; slice k at bits [k*G +: G]
- allocation_id  out  IW  base index of new counter
- valid_allocation_id  out  1  one-cycle pulse, allocation succeeded
- alloc_fail  out  1  one-cycle pulse, allocation failed
- rdata_out  out  G  read beat
- valid_data_out  out  1  read beat valid
- last  out  1  final read beat
- ovf  out  N  sticky wrap/saturate flag, indexed by base slice
- cmd_err  out  1  one-cycle pulse, illegal command dropped

## Operation
- State held per slice:
  - free bit
  - head bit (counter base)
  - per head: size (IW+1 bits), sat bit, ovf bit
- A counter's value is the concatenation of slices id..id+size-1, with the LS slice at id.
- Legal target: id < N and head[id]=1. Any other id for inc/dec/dealloc/load/read/clear gives cmd_err and no state change.
- inc / dec:
  - ±1 on the full size*G-bit value; carry/borrow propagates across slices, never beyond the counter.
  - Wrap mode: all-ones+1 gives 0 and sets ovf; 0-1 gives all-ones and sets ovf.
  - Sat mode: the value holds at all-ones (inc) or 0 (dec) and sets ovf.
- alloc (first-fit):
  - Picks the lowest base b where slices b..b+size-1 are all free.
  - On success: marks them used, sets head[b], stores size and sat, clears the slices and ovf[b].
  - Size 0, size > N, or no fit gives alloc_fail.
- dealloc: frees the slices, clears head, size, ovf and the slice data.
- load: slices take load_data_in[size*G-1:0]; ovf cleared.
- clear: value set to 0; ovf cleared.
- read: streams the slices LS-first, one slice per beat, size beats in total.
- Non-idle commands issued while ready=0 are dropped silently (not cmd_err).

## Timing
- Reset values:
  - All slices free, no heads, data_out=0, ovf=0.
  - ready=1; valid_allocation_id, alloc_fail, valid_data_out, last, cmd_err all 0; allocation_id=0, rdata_out=0.
- Command sampled at edge T when ready=1. inc, dec, load, clear and dealloc update data_out, ovf and the maps at edge T; they are visible after T.
- alloc: the maps update at T. valid_allocation_id/allocation_id or alloc_fail are registered and high for exactly the cycle after T.
- cmd_err is high for the cycle after T.
- read:
  - ready drops after T.
  - Beats appear on cycles T+1..T+size, with valid_data_out=1 and last=1 on beat size only.
  - ready returns to 1 in the cycle after the last beat. A new command may be sampled then.
  - A size-1 read gives one beat with last=1.
- Reset asserted mid-read aborts the stream: the next cycle has valid_data_out=0 and ready=1, and all state is reset.
- Only one command per cycle; there are no simultaneous-event cases beyond reset, which has priority.

## Test plan
- Reset, then alloc size 3 (wrap), 1, 4 (sat), 2 -> ids 0,3,4,8 in order, each pulse one cycle after issue; a further alloc size 1 -> alloc_fail.
- Counter 0 (size 3, wrap): load 0xFFE, inc ×2 -> data_out[11:0]=0x000 and ovf[0]=1; dec -> 0xFFF.
- Counter 4 (size 4, sat): load 0xFFFF, inc -> holds at 0xFFFF, ovf[4]=1; clear -> 0, ovf[4]=0; dec -> stays 0, ovf[4]=1.
- Read counter 0 after loading 0xA5C:
  - Beats 0xC, 0x5, 0xA on T+1..T+3, last only on the third beat; ready low T+1..T+3.
  - An inc issued at T+1 is dropped.
- Dealloc 3, then alloc size 1 -> id 3. Inc id 5 (non-head) -> cmd_err pulse, data unchanged. Load with valid_load_data=0 -> cmd_err.
- Reset asserted on the second beat of a size-4 read -> next cycle valid_data_out=0, ready=1, data_out=0, all slices free.

Source files
------------

// File: rtl/shared_counter_pool.sv
// Pool of N slices of G bits, carved at run time into contiguous variable-length
// counters addressed by base slice; supports inc/dec (wrap or saturate), load, clear, read streaming.
module shared_counter_pool #(
  parameter int N  = 10,
  parameter int G  = 4,
  parameter int LW = 64,
  parameter int IW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        command_in,
  input  logic [IW-1:0]     id,
  input  logic [IW:0]       new_counter_size,
  input  logic              new_counter_sat,
  input  logic [LW-1:0]     load_data_in,
  input  logic              valid_load_data,
  output logic              ready,
  output logic [N*G-1:0]    data_out,
  output logic [IW-1:0]     allocation_id,
  output logic              valid_allocation_id,
  output logic              alloc_fail,
  output logic [G-1:0]      rdata_out,
  output logic              valid_data_out,
  output logic              last,
  output logic [N-1:0]      ovf,
  output logic              cmd_err
);

  localparam int W = N * G;

  localparam logic [2:0] CMD_INC     = 3'b001;
  localparam logic [2:0] CMD_ALLOC   = 3'b010;
  localparam logic [2:0] CMD_DEALLOC = 3'b011;
  localparam logic [2:0] CMD_LOAD    = 3'b100;
  localparam logic [2:0] CMD_READ    = 3'b101;
  localparam logic [2:0] CMD_DEC     = 3'b110;
  localparam logic [2:0] CMD_CLEAR   = 3'b111;

  typedef enum logic {ST_IDLE, ST_READ} state_t;

  state_t        state_q;
  logic [N-1:0]  free_q, free_d, head_q, head_d, sat_q, sat_d, ovf_q, ovf_d;
  logic [IW:0]   size_q [N];
  logic [IW:0]   size_d [N];
  logic [W-1:0]  data_q, data_d;

  logic [IW-1:0] alloc_id_q;
  logic          alloc_ok_q, alloc_fail_q, cmd_err_q;
  logic [G-1:0]  rdata_q;
  logic          rvalid_q, last_q;
  logic [IW-1:0] rd_base_q;
  logic [IW:0]   rd_idx_q, rd_size_q;

  logic          accept, tgt_ok, tgt_sat, fit, fit_found;
  logic          alloc_ok_d, alloc_fail_d, cmd_err_d, start_read;
  logic [IW:0]   tgt_size;
  logic [IW-1:0] fit_base;
  logic [W-1:0]  tgt_mask, lo_mask, tgt_val, new_val;
  logic [W:0]    step_res;
  int            tgt_sh, sz_req;

  // Only the low N*G bits of the load bus can ever reach a counter.
  logic unused_load_bits;
  assign unused_load_bits = ^load_data_in;

  function automatic logic [W-1:0] span_mask(input logic [IW:0] sz);
    logic [W-1:0] m;
    m = '0;
    for (int k = 0; k < N; k++)
      if (k < int'(sz)) m[k*G +: G] = '1;
    return m;
  endfunction

  function automatic logic [N-1:0] slice_bits(input logic [IW:0] sz);
    logic [N-1:0] m;
    m = '0;
    for (int k = 0; k < N; k++)
      if (k < int'(sz)) m[k] = 1'b1;
    return m;
  endfunction

  function automatic logic [G-1:0] slice_of(input logic [W-1:0] d, input int k);
    return G'(d >> (k * G));
  endfunction

  // MSB of the result flags a wrap or saturation event; v is right-aligned and within m.
  function automatic logic [W:0] step_value(input logic [W-1:0] v, input logic [W-1:0] m,
                                            input logic up, input logic sat);
    logic [W:0] r;
    if (up) begin
      if (v == m) r = sat ? {1'b1, v} : {1'b1, {W{1'b0}}};
      else        r = {1'b0, v + W'(1)};
    end else begin
      if (v == '0) r = sat ? {1'b1, v} : {1'b1, m};
      else         r = {1'b0, v - W'(1)};
    end
    return r;
  endfunction

  always_comb begin
    free_d       = free_q;
    head_d       = head_q;
    sat_d        = sat_q;
    ovf_d        = ovf_q;
    size_d       = size_q;
    data_d       = data_q;
    cmd_err_d    = 1'b0;
    alloc_ok_d   = 1'b0;
    alloc_fail_d = 1'b0;
    start_read   = 1'b0;
    accept       = (state_q == ST_IDLE);

    tgt_ok   = 1'b0;
    tgt_sat  = 1'b0;
    tgt_size = '0;
    for (int k = 0; k < N; k++) begin
      if (int'(id) == k) begin
        tgt_ok   = head_q[k];
        tgt_sat  = sat_q[k];
        tgt_size = size_q[k];
      end
    end
    tgt_sh   = int'(id) * G;
    lo_mask  = span_mask(tgt_size);
    tgt_mask = lo_mask << tgt_sh;
    tgt_val  = (data_q & tgt_mask) >> tgt_sh;
    step_res = '0;
    new_val  = tgt_val;

    // First-fit: lowest base whose whole span is free and inside the pool.
    sz_req    = int'(new_counter_size);
    fit       = 1'b0;
    fit_found = 1'b0;
    fit_base  = '0;
    for (int b = 0; b < N; b++) begin
      fit = (sz_req >= 1) && (b + sz_req <= N);
      for (int k = 0; k < N; k++)
        if (k >= b && k < b + sz_req && !free_q[k]) fit = 1'b0;
      if (fit && !fit_found) begin
        fit_found = 1'b1;
        fit_base  = IW'(b);
      end
    end

    if (accept) begin
      case (command_in)
        CMD_INC, CMD_DEC: begin
          if (tgt_ok) begin
            step_res = step_value(tgt_val, lo_mask, command_in == CMD_INC, tgt_sat);
            new_val  = step_res[W-1:0];
            if (step_res[W]) ovf_d[id] = 1'b1;
            data_d = (data_q & ~tgt_mask) | (new_val << tgt_sh);
          end else cmd_err_d = 1'b1;
        end
        CMD_LOAD: begin
          if (tgt_ok && valid_load_data) begin
            data_d    = (data_q & ~tgt_mask) | ((load_data_in[W-1:0] & lo_mask) << tgt_sh);
            ovf_d[id] = 1'b0;
          end else cmd_err_d = 1'b1;
        end
        CMD_CLEAR: begin
          if (tgt_ok) begin
            data_d    = data_q & ~tgt_mask;
            ovf_d[id] = 1'b0;
          end else cmd_err_d = 1'b1;
        end
        CMD_DEALLOC: begin
          if (tgt_ok) begin
            data_d     = data_q & ~tgt_mask;
            free_d     = free_q | (slice_bits(tgt_size) << id);
            head_d[id] = 1'b0;
            sat_d[id]  = 1'b0;
            ovf_d[id]  = 1'b0;
            size_d[id] = '0;
          end else cmd_err_d = 1'b1;
        end
        CMD_READ: begin
          if (tgt_ok) start_read = 1'b1;
          else        cmd_err_d  = 1'b1;
        end
        CMD_ALLOC: begin
          if (fit_found) begin
            alloc_ok_d       = 1'b1;
            free_d           = free_q & ~(slice_bits(new_counter_size) << fit_base);
            head_d[fit_base] = 1'b1;
            sat_d[fit_base]  = new_counter_sat;
            ovf_d[fit_base]  = 1'b0;
            size_d[fit_base] = new_counter_size;
            data_d = data_q & ~(span_mask(new_counter_size) << (int'(fit_base) * G));
          end else alloc_fail_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      free_q       <= '1;
      head_q       <= '0;
      sat_q        <= '0;
      ovf_q        <= '0;
      data_q       <= '0;
      for (int k = 0; k < N; k++) size_q[k] <= '0;
      alloc_id_q   <= '0;
      alloc_ok_q   <= 1'b0;
      alloc_fail_q <= 1'b0;
      cmd_err_q    <= 1'b0;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
      last_q       <= 1'b0;
      rd_base_q    <= '0;
      rd_idx_q     <= '0;
      rd_size_q    <= '0;
    end else begin
      free_q       <= free_d;
      head_q       <= head_d;
      sat_q        <= sat_d;
      ovf_q        <= ovf_d;
      data_q       <= data_d;
      size_q       <= size_d;
      alloc_ok_q   <= alloc_ok_d;
      alloc_fail_q <= alloc_fail_d;
      cmd_err_q    <= cmd_err_d;
      if (alloc_ok_d) alloc_id_q <= fit_base;
      case (state_q)
        ST_IDLE: begin
          if (start_read) begin
            state_q   <= ST_READ;
            rvalid_q  <= 1'b1;
            rdata_q   <= slice_of(data_q, int'(id));
            last_q    <= (tgt_size == (IW+1)'(1));
            rd_base_q <= id;
            rd_idx_q  <= '0;
            rd_size_q <= tgt_size;
          end
        end
        ST_READ: begin
          if (last_q) begin
            state_q  <= ST_IDLE;
            rvalid_q <= 1'b0;
            last_q   <= 1'b0;
            rdata_q  <= '0;
          end else begin
            rd_idx_q <= rd_idx_q + (IW+1)'(1);
            rdata_q  <= slice_of(data_q, int'(rd_base_q) + int'(rd_idx_q) + 1);
            last_q   <= (int'(rd_idx_q) + 2 == int'(rd_size_q));
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ready               = (state_q == ST_IDLE);
  assign data_out            = data_q;
  assign ovf                 = ovf_q;
  assign allocation_id       = alloc_id_q;
  assign valid_allocation_id = alloc_ok_q;
  assign alloc_fail          = alloc_fail_q;
  assign cmd_err             = cmd_err_q;
  assign rdata_out           = rdata_q;
  assign valid_data_out      = rvalid_q;
  assign last                = last_q;

endmodule

// File: tb/tb_shared_counter_pool.sv
// Bench for shared_counter_pool: directed scenarios then random commands,
// checked against a per-counter arithmetic model (value, size, mode, flag per base).
module tb_shared_counter_pool;

  localparam int N  = 10;
  localparam int G  = 4;
  localparam int LW = 64;
  localparam int IW = 4;
  localparam int W  = N * G;

  localparam logic [2:0] C_IDLE = 3'b000, C_INC = 3'b001, C_ALLOC = 3'b010, C_DEALLOC = 3'b011;
  localparam logic [2:0] C_LOAD = 3'b100, C_READ = 3'b101, C_DEC = 3'b110, C_CLEAR = 3'b111;

  logic            clk, rst;
  logic [2:0]      command_in;
  logic [IW-1:0]   id;
  logic [IW:0]     new_counter_size;
  logic            new_counter_sat;
  logic [LW-1:0]   load_data_in;
  logic            valid_load_data;
  logic            ready;
  logic [W-1:0]    data_out;
  logic [IW-1:0]   allocation_id;
  logic            valid_allocation_id, alloc_fail;
  logic [G-1:0]    rdata_out;
  logic            valid_data_out, last;
  logic [N-1:0]    ovf;
  logic            cmd_err;

  shared_counter_pool #(.N(N), .G(G), .LW(LW), .IW(IW)) dut (
    .clk(clk), .rst(rst), .command_in(command_in), .id(id),
    .new_counter_size(new_counter_size), .new_counter_sat(new_counter_sat),
    .load_data_in(load_data_in), .valid_load_data(valid_load_data),
    .ready(ready), .data_out(data_out), .allocation_id(allocation_id),
    .valid_allocation_id(valid_allocation_id), .alloc_fail(alloc_fail),
    .rdata_out(rdata_out), .valid_data_out(valid_data_out), .last(last),
    .ovf(ovf), .cmd_err(cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one entry per live counter, keyed by its base slice.
  bit              m_live [N];
  int              m_size [N];
  bit              m_sat  [N];
  bit              m_ovf  [N];
  longint unsigned m_val  [N];

  function automatic longint unsigned vmax(int sz);
    return (64'd1 << (sz * G)) - 64'd1;
  endfunction

  function automatic bit used_slice(int k);
    for (int b = 0; b < N; b++)
      if (m_live[b] && k >= b && k < b + m_size[b]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] exp_data();
    logic [W-1:0] e;
    e = '0;
    for (int b = 0; b < N; b++)
      if (m_live[b]) e = e | (W'(m_val[b]) << (b * G));
    return e;
  endfunction

  function automatic logic [N-1:0] exp_ovf();
    logic [N-1:0] e;
    e = '0;
    for (int b = 0; b < N; b++) e[b] = m_live[b] & m_ovf[b];
    return e;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < N; b++) begin
      m_live[b] = 0; m_size[b] = 0; m_sat[b] = 0; m_ovf[b] = 0; m_val[b] = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one command, predict its effect, and check everything up to the point ready returns.
  task automatic run_cmd(input logic [2:0] c, input int tid, input int sz, input bit sat,
                         input logic [63:0] ld, input bit vld, input bit drop);
    bit legal, e_err, e_aok, e_afail, found;
    int e_aid, rd_n, rd_b;
    e_err = 0; e_aok = 0; e_afail = 0; e_aid = 0; rd_n = 0; rd_b = 0; found = 0;
    legal = (tid < N) && m_live[tid];
    case (c)
      C_INC: if (!legal) e_err = 1;
             else if (m_val[tid] == vmax(m_size[tid])) begin
               m_ovf[tid] = 1; if (!m_sat[tid]) m_val[tid] = 0;
             end else m_val[tid] = m_val[tid] + 1;
      C_DEC: if (!legal) e_err = 1;
             else if (m_val[tid] == 0) begin
               m_ovf[tid] = 1; if (!m_sat[tid]) m_val[tid] = vmax(m_size[tid]);
             end else m_val[tid] = m_val[tid] - 1;
      C_LOAD: if (!legal || !vld) e_err = 1;
              else begin m_val[tid] = ld & vmax(m_size[tid]); m_ovf[tid] = 0; end
      C_CLEAR: if (!legal) e_err = 1;
               else begin m_val[tid] = 0; m_ovf[tid] = 0; end
      C_DEALLOC: if (!legal) e_err = 1;
                 else begin m_live[tid] = 0; m_size[tid] = 0; m_val[tid] = 0; m_ovf[tid] = 0; end
      C_READ: if (!legal) e_err = 1;
              else begin rd_n = m_size[tid]; rd_b = tid; end
      C_ALLOC: begin
        if (sz >= 1 && sz <= N) begin
          for (int b = 0; b + sz <= N && !found; b++) begin
            bit ok;
            ok = 1;
            for (int k = b; k < b + sz; k++) if (used_slice(k)) ok = 0;
            if (ok) begin
              found = 1; e_aid = b;
              m_live[b] = 1; m_size[b] = sz; m_sat[b] = sat; m_ovf[b] = 0; m_val[b] = 0;
            end
          end
        end
        e_aok = found; e_afail = !found;
      end
      default: ;
    endcase

    command_in = c; id = IW'(tid); new_counter_size = (IW+1)'(sz);
    new_counter_sat = sat; load_data_in = ld; valid_load_data = vld;
    @(posedge clk); #1;
    command_in = C_IDLE; valid_load_data = 1'b0;

    chk("cmd_err", cmd_err, e_err);
    chk("alloc_ok", valid_allocation_id, e_aok);
    chk("alloc_fail", alloc_fail, e_afail);
    if (e_aok) chk("alloc_id", allocation_id, e_aid);
    for (int i = 0; i < rd_n; i++) begin
      chk("rd_ready", ready, 0);
      chk("rd_valid", valid_data_out, 1);
      chk("rd_data", rdata_out, (m_val[rd_b] >> (i * G)) & 64'hF);
      chk("rd_last", last, (i == rd_n - 1));
      if (drop && i == 0) begin command_in = C_INC; id = IW'(tid); end
      @(posedge clk); #1;
      command_in = C_IDLE;
    end
    chk("ready", ready, 1);
    chk("valid_data_out", valid_data_out, 0);
    chk("data_out", data_out, exp_data());
    chk("ovf", ovf, exp_ovf());
  endtask

  initial begin
    int q[$];
    int c, tid, sz;
    logic [63:0] ld;
    bit vld, sat, drop;

    rst = 1'b1; command_in = C_IDLE; id = '0; new_counter_size = '0;
    new_counter_sat = 1'b0; load_data_in = '0; valid_load_data = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_ready", ready, 1);
    chk("rst_data", data_out, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_alloc_ok", valid_allocation_id, 0);
    chk("rst_alloc_fail", alloc_fail, 0);
    chk("rst_alloc_id", allocation_id, 0);
    chk("rst_valid", valid_data_out, 0);
    chk("rst_last", last, 0);
    chk("rst_rdata", rdata_out, 0);
    chk("rst_cmd_err", cmd_err, 0);

    run_cmd(C_ALLOC, 0, 3, 0, 0, 0, 0);  chk("alloc3_id", allocation_id, 0);
    run_cmd(C_IDLE, 0, 0, 0, 0, 0, 0);   chk("alloc_pulse_gone", valid_allocation_id, 0);
    run_cmd(C_ALLOC, 0, 1, 0, 0, 0, 0);  chk("alloc1_id", allocation_id, 3);
    run_cmd(C_ALLOC, 0, 4, 1, 0, 0, 0);  chk("alloc4_id", allocation_id, 4);
    run_cmd(C_ALLOC, 0, 2, 0, 0, 0, 0);  chk("alloc2_id", allocation_id, 8);
    run_cmd(C_ALLOC, 0, 1, 0, 0, 0, 0);  chk("alloc_full", alloc_fail, 1);

    run_cmd(C_LOAD, 0, 0, 0, 64'hFFE, 1, 0);
    run_cmd(C_INC, 0, 0, 0, 0, 0, 0);
    run_cmd(C_INC, 0, 0, 0, 0, 0, 0);
    chk("wrap_inc_val", data_out[11:0], 12'h000);
    chk("wrap_inc_ovf", ovf[0], 1);
    run_cmd(C_DEC, 0, 0, 0, 0, 0, 0);
    chk("wrap_dec_val", data_out[11:0], 12'hFFF);

    run_cmd(C_LOAD, 4, 0, 0, 64'hFFFF, 1, 0);
    run_cmd(C_INC, 4, 0, 0, 0, 0, 0);
    chk("sat_inc_val", data_out[31:16], 16'hFFFF);
    chk("sat_inc_ovf", ovf[4], 1);
    run_cmd(C_CLEAR, 4, 0, 0, 0, 0, 0);
    chk("clear_val", data_out[31:16], 16'h0000);
    chk("clear_ovf", ovf[4], 0);
    run_cmd(C_DEC, 4, 0, 0, 0, 0, 0);
    chk("sat_dec_val", data_out[31:16], 16'h0000);
    chk("sat_dec_ovf", ovf[4], 1);

    run_cmd(C_LOAD, 0, 0, 0, 64'hA5C, 1, 0);
    run_cmd(C_READ, 0, 0, 0, 0, 0, 1);
    chk("read_drop_inc", data_out[11:0], 12'hA5C);

    run_cmd(C_DEALLOC, 3, 0, 0, 0, 0, 0);
    run_cmd(C_ALLOC, 0, 1, 0, 0, 0, 0);  chk("realloc_id", allocation_id, 3);
    run_cmd(C_INC, 5, 0, 0, 0, 0, 0);    chk("nonhead_err", cmd_err, 1);
    run_cmd(C_LOAD, 0, 0, 0, 64'h123, 0, 0); chk("noload_err", cmd_err, 1);

    // Reset during the second beat of a size-4 read.
    run_cmd(C_LOAD, 4, 0, 0, 64'h1234, 1, 0);
    command_in = C_READ; id = IW'(4);
    @(posedge clk); #1;
    command_in = C_IDLE;
    chk("rr_beat0", rdata_out, 4'h4);
    @(posedge clk); #1;
    chk("rr_beat1", rdata_out, 4'h3);
    chk("rr_beat1_valid", valid_data_out, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("rr_valid", valid_data_out, 0);
    chk("rr_ready", ready, 1);
    chk("rr_data", data_out, 0);
    chk("rr_ovf", ovf, 0);
    run_cmd(C_ALLOC, 0, N, 0, 0, 0, 0);
    chk("rr_all_free", valid_allocation_id, 1);

    for (int it = 0; it < 400; it++) begin
      q.delete();
      for (int b = 0; b < N; b++) if (m_live[b]) q.push_back(b);
      c = int'($urandom_range(0, 7));
      if (q.size() > 0 && $urandom_range(0, 4) != 0) tid = q[$urandom_range(0, q.size() - 1)];
      else tid = int'($urandom_range(0, 15));
      sz = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, N + 1)) : int'($urandom_range(1, 3));
      case ($urandom_range(0, 3))
        0:       ld = '1;
        1:       ld = '0;
        default: ld = {$urandom, $urandom};
      endcase
      vld  = ($urandom_range(0, 7) != 0);
      sat  = 1'($urandom_range(0, 1));
      drop = 1'($urandom_range(0, 1));
      run_cmd(3'(c), tid, sz, sat, ld, vld, drop);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
